register_16b: RTL and testbench



---
 rtl/register_16b.sv | 29 ++
 tb/tb_register_16b.sv | 132 +++++++++++++
 2 files changed

// File: rtl/register_16b.sv
// General-purpose storage register with write enable and async active-low reset.
// Used for PC, IR, general and pipeline registers; out comes straight from the flops.
module register_16b #(
    parameter int                WIDTH       = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             w_flag,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (w_flag) data_d = in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= RESET_VALUE;
        else          data_q <= data_d;
    end

    assign out = data_q;

endmodule

// File: tb/tb_register_16b.sv
// Directed bench for register_16b: a vector table applied edge by edge, plus
// hand-written sequences for async reset between edges and mid-cycle input changes.
module tb_register_16b;

    logic        clk;
    logic        reset_n;
    logic [15:0] din;
    logic        w_flag;
    logic [15:0] dout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rst_n;
        logic        w;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [13];

    register_16b dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (din),
        .w_flag  (w_flag),
        .out     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] exp);
        n_vec++;
        if (dout !== exp) begin
            n_err++;
            $display("FAIL %s: out=%h expected=%h at %0t", name, dout, exp, $time);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 16'hAA55, 16'hAA55};
        vecs[2]  = '{1'b1, 1'b1, 16'hFF00, 16'hFF00};
        vecs[3]  = '{1'b1, 1'b0, 16'hFFFF, 16'hFF00};
        vecs[4]  = '{1'b1, 1'b0, 16'hF0F0, 16'hFF00};
        vecs[5]  = '{1'b1, 1'b1, 16'h0001, 16'h0001};
        vecs[6]  = '{1'b1, 1'b1, 16'h8000, 16'h8000};
        vecs[7]  = '{1'b1, 1'b1, 16'h5A5A, 16'h5A5A};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'h5A5A};
        vecs[9]  = '{1'b1, 1'b1, 16'h0000, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[11] = '{1'b0, 1'b1, 16'h1234, 16'h0000};
        vecs[12] = '{1'b1, 1'b1, 16'hC3C3, 16'hC3C3};

        // Reset asserted with write enabled and all-ones data, clock running.
        reset_n = 1'b1;
        din     = 16'hFFFF;
        w_flag  = 1'b1;
        #2 reset_n = 1'b0;
        #1 check("reset_async_before_edge", 16'h0000);
        repeat (3) @(posedge clk);
        #1 check("reset_held_clk_high", 16'h0000);
        @(negedge clk);
        check("reset_held_clk_low", 16'h0000);

        // Release with w_flag low: value stays at reset value.
        reset_n = 1'b1;
        w_flag  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("after_release_hold", 16'h0000);

        for (int i = 0; i < 13; i++) begin
            reset_n = vecs[i].rst_n;
            w_flag  = vecs[i].w;
            din     = vecs[i].din;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Async reset pulse between edges wipes a stored value immediately.
        w_flag = 1'b1;
        din    = 16'hFF00;
        @(posedge clk);
        @(negedge clk);
        check("pre_pulse_value", 16'hFF00);
        w_flag = 1'b0;
        #1 reset_n = 1'b0;
        #1 check("reset_pulse_immediate", 16'h0000);
        reset_n = 1'b1;
        #1 check("reset_pulse_released", 16'h0000);
        w_flag = 1'b1;
        din    = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        check("write_after_pulse", 16'h1234);

        // Input changes while clk is high only land on the next rising edge.
        din = 16'h1111;
        @(posedge clk);
        #1 check("write_1111_clk_high", 16'h1111);
        din = 16'h2222;
        #1 check("in_change_clk_high", 16'h1111);
        @(negedge clk);
        check("falling_edge_no_effect", 16'h1111);
        @(posedge clk);
        @(negedge clk);
        check("next_edge_captures", 16'h2222);

        // w_flag toggled high between edges but low at the edge: no write.
        w_flag = 1'b0;
        din    = 16'hBEEF;
        @(posedge clk);
        #1 w_flag = 1'b1;
        #1 w_flag = 1'b0;
        @(negedge clk);
        check("wflag_glitch_between_edges", 16'h2222);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
